cache_set_array: RTL and testbench

- Parametrised set-associative tag/data store for the lab data cache; successor of the direct-mapped single-way line store.
- Adds N-way lookup, per-set round-robin victim selection, byte-enabled writes, multi-word line fill, and a hardware invalidate-all sweep on reset or on request.
- Sits between the cache controller FSM (which owns the memory handshake and writeback) and the CPU data port.

---
 rtl/cache_set_array.sv | 178 +++++++++++++++++
 tb/tb_cache_set_array.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_set_array.sv
// Set-associative tag/data store for the lab data cache.
// Round-robin victims, byte-enabled stores, multi-word fills, invalidate sweep.
module cache_set_array #(
    parameter  int ADDR_BITS        = 32,
    parameter  int INDEX_WIDTH      = 6,
    parameter  int LINE_WORDS_WIDTH = 2,
    parameter  int WAY_WIDTH        = 1,
    localparam int TAG_BITS = ADDR_BITS - INDEX_WIDTH - LINE_WORDS_WIDTH - 2,
    localparam int WW       = (WAY_WIDTH > 0) ? WAY_WIDTH : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 load,
    input  logic                 load_last,
    input  logic                 edit,
    input  logic [3:0]           wstrb,
    input  logic                 invalid,
    input  logic                 flush_all,
    input  logic [31:0]          din,
    output logic                 hit,
    output logic [WW-1:0]        hit_way,
    output logic [WW-1:0]        victim_way,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag,
    output logic [31:0]          dout,
    output logic                 busy
);

    localparam int WAYS = 1 << WAY_WIDTH;
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WPL  = 1 << LINE_WORDS_WIDTH;
    localparam int DIW  = INDEX_WIDTH + LINE_WORDS_WIDTH;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]            dout_q, dout_d;

    logic                   valid_q [WAYS][SETS];
    logic                   dirty_q [WAYS][SETS];
    logic [TAG_BITS-1:0]    tag_q   [WAYS][SETS];
    logic [31:0]            data_q  [WAYS][SETS*WPL];
    logic [WW-1:0]          rr_q    [SETS];

    logic [TAG_BITS-1:0]         a_tag;
    logic [INDEX_WIDTH-1:0]      a_idx;
    logic [LINE_WORDS_WIDTH-1:0] a_word;
    logic [DIW-1:0]              a_didx;
    logic                        unused_addr;

    assign a_tag       = addr[ADDR_BITS-1 -: TAG_BITS];
    assign a_idx       = addr[LINE_WORDS_WIDTH+2 +: INDEX_WIDTH];
    assign a_word      = addr[2 +: LINE_WORDS_WIDTH];
    assign a_didx      = {a_idx, a_word};
    assign unused_addr = ^addr[1:0];

    logic          hit_c;
    logic [WW-1:0] hway_c;
    logic [WW-1:0] vic_c;

    // Descending scan so the lowest-numbered way wins both searches.
    always_comb begin
        hit_c  = 1'b0;
        hway_c = '0;
        vic_c  = (WAYS > 1) ? rr_q[a_idx] : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
                hit_c  = 1'b1;
                hway_c = WW'(w);
            end
            if (!valid_q[w][a_idx]) begin
                vic_c = WW'(w);
            end
        end
    end

    assign busy       = (state_q == CLEAR);
    assign hit        = hit_c & ~busy;
    assign hit_way    = busy ? '0 : hway_c;
    assign victim_way = busy ? '0 : vic_c;
    assign valid      = ~busy & valid_q[vic_c][a_idx];
    assign dirty      = ~busy & dirty_q[vic_c][a_idx];
    assign tag        = busy ? '0 : tag_q[vic_c][a_idx];
    assign dout       = dout_q;

    logic req_ok;
    logic do_inv;
    logic do_load;
    logic do_edit;
    logic rr_adv;
    logic sweep_clr;

    assign req_ok    = ~busy & ~rst;
    assign do_inv    = req_ok & invalid & hit_c;
    assign do_load   = req_ok & ~invalid & load;
    assign do_edit   = req_ok & ~invalid & ~load & edit & hit_c;
    assign rr_adv    = (WAYS > 1) & load_last & valid_q[vic_c][a_idx];
    assign sweep_clr = busy & ~rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_all) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        dout_d = '0;
        if (hit) begin
            dout_d = data_q[hway_c][a_didx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // Array storage has no reset; the sweep clears only the state bits.
    always_ff @(posedge clk) begin
        if (sweep_clr) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w][cnt_q] <= 1'b0;
                dirty_q[w][cnt_q] <= 1'b0;
            end
            rr_q[cnt_q] <= '0;
        end
        if (do_inv) begin
            valid_q[hway_c][a_idx] <= 1'b0;
            dirty_q[hway_c][a_idx] <= 1'b0;
        end
        if (do_load) begin
            data_q[vic_c][a_didx] <= din;
            if (load_last) begin
                tag_q[vic_c][a_idx]   <= a_tag;
                valid_q[vic_c][a_idx] <= 1'b1;
                dirty_q[vic_c][a_idx] <= 1'b0;
                if (rr_adv) begin
                    rr_q[a_idx] <= rr_q[a_idx] + WW'(1);
                end
            end
        end
        if (do_edit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    data_q[hway_c][a_didx][8*b +: 8] <= din[8*b +: 8];
                end
            end
            dirty_q[hway_c][a_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_set_array.sv
// Directed bench for cache_set_array: sweep, fill, evict, store,
// invalidate priority and reset-during-sweep.
module tb_cache_set_array;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        load;
    logic        load_last;
    logic        edit;
    logic [3:0]  wstrb;
    logic        invalid;
    logic        flush_all;
    logic [31:0] din;
    logic        hit;
    logic [0:0]  hit_way;
    logic [0:0]  victim_way;
    logic        valid;
    logic        dirty;
    logic [21:0] tag;
    logic [31:0] dout;
    logic        busy;

    int n_cmp;
    int n_bad;
    int n;

    cache_set_array dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .load       (load),
        .load_last  (load_last),
        .edit       (edit),
        .wstrb      (wstrb),
        .invalid    (invalid),
        .flush_all  (flush_all),
        .din        (din),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .valid      (valid),
        .dirty      (dirty),
        .tag        (tag),
        .dout       (dout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string t, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", t, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load      = 1'b0;
        load_last = 1'b0;
        edit      = 1'b0;
        wstrb     = 4'h0;
        invalid   = 1'b0;
        flush_all = 1'b0;
        din       = '0;
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] d0,
                        input logic [31:0] step, input logic [31:0] vic);
        for (int w = 0; w < 4; w++) begin
            addr      = base + 32'(w * 4);
            din       = d0 + 32'(w) * step;
            load      = 1'b1;
            load_last = (w == 3);
            #1;
            check("fill_victim", 32'(victim_way), vic);
            tick();
        end
        idle();
    endtask

    task automatic look(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    task automatic rd(input string t, input logic [31:0] a,
                      input logic [31:0] exp);
        addr = a;
        tick();
        check(t, dout, exp);
    endtask

    // Counts busy cycles; a stuck busy stops at 200 and shows as a bad length.
    task automatic count_busy(output int c);
        c = 0;
        while (busy === 1'b1 && c < 200) begin
            c++;
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        addr = '0;
        rst  = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_dout", dout, 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        rst = 1'b0;
        count_busy(n);
        check("sweep_len_rst", 32'(n), 32'd64);

        look(32'h0000_1000);
        check("empty_hit", 32'(hit), 32'd0);
        check("empty_valid", 32'(valid), 32'd0);
        rd("empty_dout", 32'h0000_1000, 32'd0);
        look(32'hFFFF_FFF0);
        check("empty_hit_hi", 32'(hit), 32'd0);
        rd("empty_dout_hi", 32'hFFFF_FFF0, 32'd0);

        fill(32'h0000_1000, 32'hA0, 32'd1, 32'd0);
        look(32'h0000_1008);
        check("f1_hit", 32'(hit), 32'd1);
        check("f1_hit_way", 32'(hit_way), 32'd0);
        check("f1_victim", 32'(victim_way), 32'd1);
        check("f1_vic_valid", 32'(valid), 32'd0);
        rd("f1_dout", 32'h0000_1008, 32'hA2);

        fill(32'h0000_1010, 32'hB0, 32'd1, 32'd0);
        rd("set1_dout", 32'h0000_1018, 32'hB2);
        look(32'h0000_0010);
        check("set1_tag_miss", 32'(hit), 32'd0);

        fill(32'h0000_2000, 32'hFFFF_FFFF, 32'd0, 32'd1);
        look(32'h0000_3000);
        check("full_hit", 32'(hit), 32'd0);
        check("full_victim", 32'(victim_way), 32'd0);
        check("full_valid", 32'(valid), 32'd1);
        check("full_tag", 32'(tag), 32'h4);
        check("full_dirty", 32'(dirty), 32'd0);

        fill(32'h0000_3000, 32'hC0, 32'd1, 32'd0);
        look(32'h0000_1000);
        check("evict_hit", 32'(hit), 32'd0);
        check("evict_victim", 32'(victim_way), 32'd1);
        check("evict_tag", 32'(tag), 32'h8);
        look(32'h0000_3004);
        check("w0_hit_way", 32'(hit_way), 32'd0);
        rd("w0_dout", 32'h0000_3004, 32'hC1);
        look(32'h0000_200C);
        check("w1_hit_way", 32'(hit_way), 32'd1);
        rd("w1_dout", 32'h0000_200C, 32'hFFFF_FFFF);

        addr  = 32'h0000_2004;
        din   = 32'h1122_3344;
        wstrb = 4'b0101;
        edit  = 1'b1;
        #1;
        check("pre_edit_dirty", 32'(dirty), 32'd0);
        tick();
        idle();
        check("edit_rbw_dout", dout, 32'hFFFF_FFFF);
        look(32'h0000_2004);
        check("edit_dirty", 32'(dirty), 32'd1);
        rd("edit_dout", 32'h0000_2004, 32'hFF22_FF44);

        addr  = 32'h0000_4000;
        din   = 32'h0;
        wstrb = 4'hF;
        edit  = 1'b1;
        #1;
        check("miss_edit_hit", 32'(hit), 32'd0);
        tick();
        idle();
        rd("miss_edit_w0", 32'h0000_3000, 32'hC0);
        rd("miss_edit_w1", 32'h0000_2000, 32'hFFFF_FFFF);
        rd("miss_edit_keep", 32'h0000_2004, 32'hFF22_FF44);

        addr      = 32'h0000_3000;
        din       = 32'hDEAD_BEEF;
        invalid   = 1'b1;
        load      = 1'b1;
        load_last = 1'b1;
        #1;
        check("inv_pre_hit", 32'(hit), 32'd1);
        tick();
        idle();
        look(32'h0000_3000);
        check("inv_hit", 32'(hit), 32'd0);
        check("inv_victim", 32'(victim_way), 32'd0);
        check("inv_valid", 32'(valid), 32'd0);
        look(32'h0000_2000);
        check("inv_other_hit", 32'(hit), 32'd1);
        rd("inv_no_load", 32'h0000_2000, 32'hFFFF_FFFF);

        addr      = 32'h0000_2000;
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            flush_all = (n == 10);
            tick();
        end
        flush_all = 1'b0;
        check("sweep_len_flush", 32'(n), 32'd64);
        look(32'h0000_2000);
        check("flush_hit", 32'(hit), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        rd("flush_dout", 32'h0000_2000, 32'd0);
        look(32'h0000_1018);
        check("flush_set1", 32'(hit), 32'd0);

        fill(32'h0000_1050, 32'h50, 32'd1, 32'd0);
        rd("set5_dout", 32'h0000_1054, 32'h51);
        addr      = 32'h0000_1050;
        flush_all = 1'b1;
        tick();
        flush_all = 1'b0;
        check("busy_gate_busy", 32'(busy), 32'd1);
        check("busy_gate_hit", 32'(hit), 32'd0);
        tick();
        check("busy_gate_dout", dout, 32'd0);
        repeat (29) tick();
        check("mid_sweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        check("sweep_len_restart", 32'(n), 32'd64);
        look(32'h0000_1050);
        check("restart_hit", 32'(hit), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
